// File: rtl/wire_bus_arbiter.sv
// Round-robin arbiter sharing one DATA_W-bit bus wire among NREQ requesters.
// Holds a grant while the owner requests, up to MAX_BURST cycles, then rotates.
module wire_bus_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy,
  output logic                     bus_valid,
  output logic [DATA_W-1:0]        bus_data
);

  localparam int OW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [OW-1:0] LAST_IDX  = OW'(NREQ - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state_r, state_n_s;
  logic [NREQ-1:0]   gnt_r, gnt_n_s;
  logic [OW-1:0]     owner_r, owner_n_s;
  logic [OW-1:0]     ptr_r, ptr_n_s;
  logic [BW-1:0]     burst_cnt_r, burst_cnt_n_s;
  logic [OW-1:0]     owner_inc_s;
  logic [OW-1:0]     search_ptr_s;
  logic              release_s;
  logic [OW:0]       winner_s;
  logic              win_found_s;
  logic [OW-1:0]     win_idx_s;
  logic              bus_valid_s;
  logic [DATA_W-1:0] bus_data_s;

  // Returns {found, index} of the first requester at or after start, wrapping.
  function automatic logic [OW:0] find_winner(input logic [NREQ-1:0] r,
                                              input logic [OW-1:0]   start);
    logic [OW:0]   res;
    logic [OW-1:0] idx_l;
    int            idx;
    res = '0;
    // Scan farthest-first so the nearest hit is the one that sticks.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      idx_l = OW'(idx);
      if (r[idx_l]) begin
        res = {1'b1, idx_l};
      end
    end
    return res;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [OW-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

  // Priority start for the search: the owner's successor on release, else ptr.
  always_comb begin
    owner_inc_s  = owner_r + OW'(1);
    search_ptr_s = ptr_r;
    if (owner_r == LAST_IDX) begin
      owner_inc_s = '0;
    end else begin
      owner_inc_s = owner_r + OW'(1);
    end
    release_s = !req[owner_r] || (burst_cnt_r == BURST_MAX);
    if (state_r == GRANT) begin
      search_ptr_s = owner_inc_s;
    end else begin
      search_ptr_s = ptr_r;
    end
  end

  assign winner_s    = find_winner(req, search_ptr_s);
  assign win_found_s = winner_s[OW];
  assign win_idx_s   = winner_s[OW-1:0];

  // Next-state and next-grant decision.
  always_comb begin
    state_n_s     = state_r;
    gnt_n_s       = gnt_r;
    owner_n_s     = owner_r;
    ptr_n_s       = ptr_r;
    burst_cnt_n_s = burst_cnt_r;
    case (state_r)
      IDLE: begin
        if (win_found_s) begin
          state_n_s     = GRANT;
          gnt_n_s       = onehot(win_idx_s);
          owner_n_s     = win_idx_s;
          burst_cnt_n_s = BW'(1);
        end else begin
          state_n_s     = IDLE;
          gnt_n_s       = '0;
          burst_cnt_n_s = '0;
        end
      end
      GRANT: begin
        if (!release_s) begin
          burst_cnt_n_s = burst_cnt_r + BW'(1);
        end else begin
          // Handover happens on the same edge, so there is no idle bubble.
          ptr_n_s = owner_inc_s;
          if (win_found_s) begin
            state_n_s     = GRANT;
            gnt_n_s       = onehot(win_idx_s);
            owner_n_s     = win_idx_s;
            burst_cnt_n_s = BW'(1);
          end else begin
            state_n_s     = IDLE;
            gnt_n_s       = '0;
            burst_cnt_n_s = '0;
          end
        end
      end
      default: begin
        state_n_s     = IDLE;
        gnt_n_s       = '0;
        owner_n_s     = '0;
        ptr_n_s       = '0;
        burst_cnt_n_s = '0;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      gnt_r       <= '0;
      owner_r     <= '0;
      ptr_r       <= '0;
      burst_cnt_r <= '0;
    end else begin
      state_r     <= state_n_s;
      gnt_r       <= gnt_n_s;
      owner_r     <= owner_n_s;
      ptr_r       <= ptr_n_s;
      burst_cnt_r <= burst_cnt_n_s;
    end
  end

  // Bus mux: the owner's data reaches the wire only while it still requests.
  always_comb begin
    bus_valid_s = 1'b0;
    bus_data_s  = '0;
    if (state_r == GRANT) begin
      bus_valid_s = gnt_r[owner_r] & req[owner_r];
    end else begin
      bus_valid_s = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (bus_valid_s && (owner_r == OW'(i))) begin
        bus_data_s = req_data[i*DATA_W +: DATA_W];
      end else begin
        bus_data_s = bus_data_s;
      end
    end
  end

  assign gnt       = gnt_r;
  assign owner     = owner_r;
  assign busy      = (state_r == GRANT);
  assign bus_valid = bus_valid_s;
  assign bus_data  = bus_data_s;

  wire_bus_arbiter_chk #(
    .NREQ (NREQ)
  ) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt_r),
    .owner (owner_r),
    .busy  (busy)
  );

endmodule

// Grant-legality properties for wire_bus_arbiter.
module wire_bus_arbiter_chk #(
  parameter int NREQ = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  input logic [NREQ-1:0]         req,
  input logic [NREQ-1:0]         gnt,
  input logic [$clog2(NREQ)-1:0] owner,
  input logic                    busy
);

  a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));

  a_consistent : assert property (@(posedge clk) disable iff (!rst_n)
    gnt == (busy ? (NREQ'(1) << owner) : NREQ'(0)));

  // A freshly moved grant must land on a requester that asked at the decision edge.
  a_legal : assert property (@(posedge clk) disable iff (!rst_n)
    ((|gnt) && (gnt != $past(gnt))) |-> (|($past(req) & gnt)));

endmodule

// File: tb/tb_wire_bus_arbiter.sv
// Bench for wire_bus_arbiter: a rotating-priority model checked every cycle,
// plus directed scenarios with hand-computed grant patterns.
module tb_wire_bus_arbiter;

  localparam int NREQ      = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic        bus_valid;
  logic [7:0]  bus_data;

  int n_cmp  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  // Model: who owns the wire, how long it has held it, where priority starts.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_run   = 0;
  int m_ptr   = 0;

  wire_bus_arbiter #(
    .NREQ      (NREQ),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .owner     (owner),
    .busy      (busy),
    .bus_valid (bus_valid),
    .bus_data  (bus_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit req_bit(input logic [3:0] r, input int i);
    logic [3:0] sh;
    sh = r >> i;
    return sh[0];
  endfunction

  // Model update: keep the owner while it asks and has burst left, else scan onward.
  always @(posedge clk) begin : model
    int start;
    int pick;
    int c;
    if (!rst_n) begin
      m_busy = 1'b0; m_owner = 0; m_run = 0; m_ptr = 0;
    end else if (m_busy && req_bit(req, m_owner) && m_run < MAX_BURST) begin
      m_run = m_run + 1;
    end else begin
      start = m_busy ? (m_owner + 1) % NREQ : m_ptr;
      if (m_busy) m_ptr = start;
      pick = -1;
      for (int k = 0; k < NREQ; k++) begin
        c = (start + k) % NREQ;
        if (pick < 0 && req_bit(req, c)) pick = c;
      end
      if (pick >= 0) begin
        m_busy = 1'b1; m_owner = pick; m_run = 1;
      end else begin
        m_busy = 1'b0; m_run = 0;
      end
    end
  end

  // Compare all outputs against the model mid-cycle.
  always @(negedge clk) begin : compare
    logic [3:0]  eg;
    logic        ev;
    logic [31:0] sh;
    logic [7:0]  ed;
    if (check_en) begin
      eg = m_busy ? 4'(32'd1 << m_owner) : 4'b0000;
      ev = m_busy && req_bit(req, m_owner);
      sh = req_data >> (m_owner * DATA_W);
      ed = ev ? sh[7:0] : 8'h00;
      check("m_gnt", {28'h0, gnt}, {28'h0, eg});
      check("m_busy", {31'h0, busy}, {31'h0, m_busy});
      if (m_busy) check("m_owner", {30'h0, owner}, 32'(m_owner));
      check("m_valid", {31'h0, bus_valid}, {31'h0, ev});
      check("m_data", {24'h0, bus_data}, {24'h0, ed});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin : stim
    logic [3:0] exp_g;
    req_data = {8'h3C, 8'hA5, 8'h5A, 8'h11};

    // 1: reset with all requesting, then first grant goes to requester 0
    rst_n = 1'b0; req = 4'b1111;
    tick(); check_en = 1'b1;
    tick();
    check("rst_gnt", {28'h0, gnt}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_valid", {31'h0, bus_valid}, 32'h0);
    rst_n = 1'b1;
    tick();
    check("first_gnt", {28'h0, gnt}, 32'h1);

    // 2: lone requester 2 is re-granted across the burst limit without a gap
    rst_n = 1'b0; req = 4'b0000; tick(); rst_n = 1'b1;
    req = 4'b0100;
    tick();
    check("t2_gnt", {28'h0, gnt}, 32'h4);
    check("t2_data", {24'h0, bus_data}, 32'hA5);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("t2_hold_gnt", {28'h0, gnt}, 32'h4);
      check("t2_hold_valid", {31'h0, bus_valid}, 32'h1);
    end
    req = 4'b0000;
    tick();
    check("t2_idle", {31'h0, busy}, 32'h0);

    // 3: all requesting rotates in bursts of four
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req = 4'b1111;
    for (int t = 0; t < 17; t++) begin
      tick();
      exp_g = 4'b0001 << ((t / 4) % 4);
      check("t3_rot", {28'h0, gnt}, {28'h0, exp_g});
    end

    // 4: owner 1 drops after two cycles, grant lingers one cycle then moves to 3
    rst_n = 1'b0; req = 4'b0000; tick(); rst_n = 1'b1;
    req = 4'b0010;
    tick(); tick();
    req = 4'b1000;
    #1;
    check("t4_linger_gnt", {28'h0, gnt}, 32'h2);
    check("t4_linger_valid", {31'h0, bus_valid}, 32'h0);
    tick();
    check("t4_move_gnt", {28'h0, gnt}, 32'h8);
    check("t4_move_data", {24'h0, bus_data}, 32'h3C);

    // 5: owner 3 hits its burst limit with req=1001, priority wraps to 0
    req = 4'b1001;
    tick(); tick(); tick();
    check("t5_hold", {28'h0, gnt}, 32'h8);
    tick();
    check("t5_wrap_gnt", {28'h0, gnt}, 32'h1);
    check("t5_wrap_data", {24'h0, bus_data}, 32'h11);

    // 6: reset mid-burst of owner 2 clears grant and priority
    rst_n = 1'b0; req = 4'b0000; tick(); rst_n = 1'b1;
    req = 4'b0100;
    tick(); tick();
    check("t6_pre", {28'h0, gnt}, 32'h4);
    rst_n = 1'b0;
    tick();
    check("t6_rst_gnt", {28'h0, gnt}, 32'h0);
    check("t6_rst_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1; req = 4'b1111;
    tick();
    check("t6_regnt", {28'h0, gnt}, 32'h1);

    req = 4'b0000;
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
